// File: rtl/block_animator.sv
// Moving-block animator: each tick the object is drawn, the fixed target drawn, the object erased and moved.
// Define BLOCK_ANIMATOR_WRAP_EN to wrap the object around screen edges instead of clamping.
module block_animator #(
    parameter int XSCREEN = 160,
    parameter int YSCREEN = 120,
    parameter int XDIM    = 10,
    parameter int YDIM    = 10,
    parameter int X0      = 39,
    parameter int Y0      = 59,
    parameter int AX0     = 80,
    parameter int AY0     = 60,
    parameter int K       = 20
) (
    input  logic       Clock,
    input  logic       Resetn,
    input  logic       go,
    input  logic [3:0] dir_req,
    input  logic [2:0] colour,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       plot,
    output logic [7:0] score,
    output logic       hit
);
    typedef enum logic [2:0] {IDLE, DRAW_OBJ, DRAW_TGT, WAIT, ERASE, MOVE} state_t;
    typedef enum logic [2:0] {DIR_NONE, DIR_RIGHT, DIR_DOWN, DIR_UP, DIR_LEFT} dir_t;

    localparam logic [7:0] X_MAX     = 8'(XSCREEN - XDIM);
    localparam logic [6:0] Y_MAX     = 7'(YSCREEN - YDIM);
    localparam logic [7:0] CX_LAST   = 8'(XDIM - 1);
    localparam logic [6:0] CY_LAST   = 7'(YDIM - 1);
    localparam logic [7:0] X_START   = 8'(X0);
    localparam logic [6:0] Y_START   = 7'(Y0);
    localparam logic [7:0] TGT_X     = 8'(AX0);
    localparam logic [6:0] TGT_Y     = 7'(AY0);
    localparam logic [8:0] XDIM_W    = 9'(XDIM);
    localparam logic [7:0] YDIM_W    = 8'(YDIM);
    localparam logic [8:0] TGT_X_BEG = 9'(AX0);
    localparam logic [8:0] TGT_X_END = 9'(AX0 + XDIM);
    localparam logic [7:0] TGT_Y_BEG = 8'(AY0);
    localparam logic [7:0] TGT_Y_END = 8'(AY0 + YDIM);

    state_t       state, next_state;
    dir_t         dir;
    logic [K-1:0] tick_count;
    logic         tick;
    logic [7:0]   objx, next_x;
    logic [6:0]   objy, next_y;
    logic [7:0]   cx;
    logic [6:0]   cy;
    logic         scanning;
    logic         scan_done;
    logic         overlap;

    assign tick      = (tick_count == '0);
    assign scanning  = (state == DRAW_OBJ) || (state == DRAW_TGT) || (state == ERASE);
    assign scan_done = (cx == CX_LAST) && (cy == CY_LAST);

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            tick_count <= '0;
        end else begin
            tick_count <= tick_count + 1'b1;
        end
    end

    // Latest non-zero request wins; right has the highest priority within one request.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            dir <= DIR_NONE;
        end else if (dir_req[0]) begin
            dir <= DIR_RIGHT;
        end else if (dir_req[1]) begin
            dir <= DIR_DOWN;
        end else if (dir_req[2]) begin
            dir <= DIR_UP;
        end else if (dir_req[3]) begin
            dir <= DIR_LEFT;
        end
    end

    // Counters return to zero after the last pixel, so each scan state starts at the origin.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            cx <= '0;
            cy <= '0;
        end else if (scanning && !scan_done) begin
            if (cx == CX_LAST) begin
                cx <= '0;
                cy <= cy + 1'b1;
            end else begin
                cx <= cx + 1'b1;
            end
        end else begin
            cx <= '0;
            cy <= '0;
        end
    end

    always_comb begin
        next_x = objx;
        next_y = objy;
        case (dir)
            DIR_RIGHT: begin
                if (objx < X_MAX) next_x = objx + 8'd1;
`ifdef BLOCK_ANIMATOR_WRAP_EN
                else next_x = '0;
`endif
            end
            DIR_LEFT: begin
                if (objx != '0) next_x = objx - 8'd1;
`ifdef BLOCK_ANIMATOR_WRAP_EN
                else next_x = X_MAX;
`endif
            end
            DIR_DOWN: begin
                if (objy < Y_MAX) next_y = objy + 7'd1;
`ifdef BLOCK_ANIMATOR_WRAP_EN
                else next_y = '0;
`endif
            end
            DIR_UP: begin
                if (objy != '0) next_y = objy - 7'd1;
`ifdef BLOCK_ANIMATOR_WRAP_EN
                else next_y = Y_MAX;
`endif
            end
            default: begin
                next_x = objx;
                next_y = objy;
            end
        endcase
    end

    assign overlap = ({1'b0, next_x} < TGT_X_END) && (({1'b0, next_x} + XDIM_W) > TGT_X_BEG)
                  && ({1'b0, next_y} < TGT_Y_END) && (({1'b0, next_y} + YDIM_W) > TGT_Y_BEG);

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            objx  <= X_START;
            objy  <= Y_START;
            score <= '0;
            hit   <= 1'b0;
        end else begin
            hit <= 1'b0;
            if (state == MOVE) begin
                objx <= next_x;
                objy <= next_y;
                if (overlap) begin
                    hit <= 1'b1;
                    if (score != 8'hFF) score <= score + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Pixel outputs are decoded from state so a reset silences plot immediately.
    always_comb begin
        next_state = state;
        plot       = 1'b0;
        vga_x      = '0;
        vga_y      = '0;
        vga_colour = '0;
        case (state)
            IDLE: begin
                if (go && tick) next_state = DRAW_OBJ;
            end
            DRAW_OBJ: begin
                plot       = 1'b1;
                vga_x      = objx + cx;
                vga_y      = objy + cy;
                vga_colour = colour;
                if (scan_done) next_state = DRAW_TGT;
            end
            DRAW_TGT: begin
                plot       = 1'b1;
                vga_x      = TGT_X + cx;
                vga_y      = TGT_Y + cy;
                vga_colour = 3'b100;
                if (scan_done) next_state = WAIT;
            end
            WAIT: begin
                if (tick) next_state = ERASE;
            end
            ERASE: begin
                plot  = 1'b1;
                vga_x = objx + cx;
                vga_y = objy + cy;
                if (scan_done) next_state = MOVE;
            end
            MOVE: begin
                next_state = DRAW_OBJ;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end
endmodule
